// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter controller.
//   - DEF_PC_W / DEF_IDX_W / DEF_CNT_W : default widths for the PC (and signed
//     LUT offset), the LUT index and the retired-instruction counter.
//   - pc_state_t : controller state (IDLE, RUN, DONE, FAULT).
//   - sign_extend : widens a DEF_PC_W-bit two's-complement offset by one bit.
package pc_pkg;

  localparam int DEF_PC_W  = 10;
  localparam int DEF_IDX_W = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } pc_state_t;

  function automatic logic [DEF_PC_W:0] sign_extend(input logic [DEF_PC_W-1:0] value);
    return {value[DEF_PC_W-1], value};
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Next-PC arithmetic (purely combinational).
//   pc           in  PC_W  current program counter
//   lut_out      in  PC_W  signed two's-complement branch offset
//   take         in  1     1: pc + offset, 0: pc + 1
//   target       out PC_W  low PC_W bits of the sum
//   out_of_range out 1     sum lies outside 0..2^PC_W-1
module branch_target_calc #(
  parameter int PC_W = 10
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] lut_out,
  input  logic            take,
  output logic [PC_W-1:0] target,
  output logic            out_of_range
);

  logic [PC_W:0] offset;
  logic [PC_W:0] sum;

  // The true sum spans -2^(PC_W-1) .. 2^PC_W + 2^(PC_W-1) - 2, so in PC_W+1
  // bits (mod 2^(PC_W+1)) every out-of-range value, negative or too large,
  // lands with the top bit set while every legal address has it clear.
  assign offset       = take ? {lut_out[PC_W-1], lut_out} : (PC_W+1)'(1);
  assign sum          = {1'b0, pc} + offset;
  assign target       = sum[PC_W-1:0];
  assign out_of_range = sum[PC_W];

endmodule

// File: rtl/pc_branch_ctrl.sv
// Program-counter controller for the 3BC processor.
// Runs one program per Start pulse, retires one instruction per cycle,
// follows relative branches through the offset LUT, and faults (sticky) when
// the next PC would leave the address space.
//   Clk, Reset          clock; synchronous active-high reset
//   Start, StartAddr    begin a run at StartAddr (IDLE/DONE only)
//   Halt, BranchEn,     decoded control of the instruction at ProgCtr
//   CondTrue
//   LutIdxIn/LutIndex   LUT index field, passed straight to the LUT
//   LutOut              signed PC-relative offset from the LUT
//   ProgCtr             current instruction address
//   Running/Done/Fault  state flags, decoded from the state register
//   InstrCount          saturating count of instructions retired this run
module pc_branch_ctrl
  import pc_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int IDX_W = DEF_IDX_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Halt,
  input  logic             BranchEn,
  input  logic             CondTrue,
  input  logic [IDX_W-1:0] LutIdxIn,
  output logic [IDX_W-1:0] LutIndex,
  input  logic [PC_W-1:0]  LutOut,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic             Fault,
  output logic [CNT_W-1:0] InstrCount
);

  pc_state_t        state, state_next;
  logic [PC_W-1:0]  pc_next;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] count_inc;
  logic [PC_W-1:0]  target;
  logic             out_of_range;

  assign LutIndex = LutIdxIn;

  branch_target_calc #(
    .PC_W(PC_W)
  ) u_target (
    .pc           (ProgCtr),
    .lut_out      (LutOut),
    .take         (BranchEn & CondTrue),
    .target       (target),
    .out_of_range (out_of_range)
  );

  assign count_inc = (InstrCount == '1) ? InstrCount : InstrCount + CNT_W'(1);

  // NOTE: every output of this block gets a default first; any path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = ProgCtr;
    count_next = InstrCount;
    unique case (state)
      IDLE, DONE: begin
        if (Start) begin
          state_next = RUN;
          pc_next    = StartAddr;
          count_next = '0;
        end
      end
      RUN: begin
        // The retiring instruction counts whatever it does: halt, fault or step.
        count_next = count_inc;
        if (Halt) begin
          state_next = DONE;
        end else if (out_of_range) begin
          state_next = FAULT;
        end else begin
          pc_next = target;
        end
      end
      FAULT: ;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous and discards the in-flight
  // update computed above.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      ProgCtr    <= '0;
      InstrCount <= '0;
    end else begin
      state      <= state_next;
      ProgCtr    <= pc_next;
      InstrCount <= count_next;
    end
  end

  assign Running = (state == RUN);
  assign Done    = (state == DONE);
  assign Fault   = (state == FAULT);

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Self-checking bench for pc_branch_ctrl: reset state, a table of single-
// instruction vectors, hand-written multi-cycle sequences, counter saturation
// and a randomized run against an integer reference model.
module tb_pc_branch_ctrl;

  localparam int PC_W  = 10;
  localparam int IDX_W = 8;
  localparam int CNT_W = 16;
  localparam int PC_MAX  = (1 << PC_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [PC_W-1:0]  start_addr;
  logic             halt;
  logic             branch_en;
  logic             cond_true;
  logic [IDX_W-1:0] lut_idx_in;
  logic [IDX_W-1:0] lut_index;
  logic [PC_W-1:0]  lut_out;
  logic [PC_W-1:0]  prog_ctr;
  logic             running;
  logic             done;
  logic             fault;
  logic [CNT_W-1:0] instr_count;

  int checks = 0;
  int errors = 0;

  pc_branch_ctrl #(
    .PC_W (PC_W),
    .IDX_W(IDX_W),
    .CNT_W(CNT_W)
  ) dut (
    .Clk       (clk),
    .Reset     (reset),
    .Start     (start),
    .StartAddr (start_addr),
    .Halt      (halt),
    .BranchEn  (branch_en),
    .CondTrue  (cond_true),
    .LutIdxIn  (lut_idx_in),
    .LutIndex  (lut_index),
    .LutOut    (lut_out),
    .ProgCtr   (prog_ctr),
    .Running   (running),
    .Done      (done),
    .Fault     (fault),
    .InstrCount(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_all(input string name, input int e_pc, input int e_cnt,
                           input bit e_run, input bit e_done, input bit e_fault);
    check({name, " pc"},      32'(prog_ctr),    32'(e_pc));
    check({name, " count"},   32'(instr_count), 32'(e_cnt));
    check({name, " running"}, 32'(running),     32'(e_run));
    check({name, " done"},    32'(done),        32'(e_done));
    check({name, " fault"},   32'(fault),       32'(e_fault));
  endtask

  // Inputs change only at the falling edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    halt       = 1'b0;
    branch_en  = 1'b0;
    cond_true  = 1'b0;
    lut_idx_in = '0;
    lut_out    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_start(input int addr);
    start      = 1'b1;
    start_addr = PC_W'(addr);
    tick();
    start      = 1'b0;
  endtask

  typedef struct {
    string      name;
    int         start_pc;
    bit         h, br, cond;
    logic [9:0] lut;
    int         exp_pc;
    bit         exp_run, exp_done, exp_fault;
  } vec_t;

  vec_t vecs[12];

  // Reference model state (plain integers, one flag per mode).
  int m_pc, m_cnt;
  bit m_run, m_done, m_fault;

  function automatic int offset_of(input logic [9:0] v);
    int u;
    u = int'(v);
    return (u >= 512) ? u - 1024 : u;
  endfunction

  initial begin
    idle_inputs();
    @(negedge clk);

    // Reset state
    do_reset();
    check_all("reset", 0, 0, 0, 0, 0);

    // LUT index passthrough
    lut_idx_in = 8'hA5;
    #1;
    check("lut_index", 32'(lut_index), 32'h0000_00A5);
    lut_idx_in = '0;

    // Single-instruction vectors: reset, start at start_pc, retire one instruction.
    vecs[0]  = '{"branch back -459",   477, 0, 1, 1, 10'h235,  18, 1, 0, 0};
    vecs[1]  = '{"cond false",         477, 0, 1, 0, 10'h235, 478, 1, 0, 0};
    vecs[2]  = '{"halt over branch",   100, 1, 1, 1, 10'h005, 100, 0, 1, 0};
    vecs[3]  = '{"branch below zero",    5, 0, 1, 1, 10'h3FA,   5, 0, 0, 1};
    vecs[4]  = '{"step past top",     1023, 0, 0, 0, 10'h000,1023, 0, 0, 1};
    vecs[5]  = '{"step to top",       1022, 0, 0, 0, 10'h000,1023, 1, 0, 0};
    vecs[6]  = '{"min offset at 0",      0, 0, 1, 1, 10'h200,   0, 0, 0, 1};
    vecs[7]  = '{"min offset to 0",    512, 0, 1, 1, 10'h200,   0, 1, 0, 0};
    vecs[8]  = '{"max offset to top",  512, 0, 1, 1, 10'h1FF,1023, 1, 0, 0};
    vecs[9]  = '{"max offset past",    513, 0, 1, 1, 10'h1FF, 513, 0, 0, 1};
    vecs[10] = '{"minus one at top",  1023, 0, 1, 1, 10'h3FF,1022, 1, 0, 0};
    vecs[11] = '{"cond without br",      0, 0, 0, 1, 10'h3FF,   1, 1, 0, 0};

    for (int i = 0; i < 12; i++) begin
      do_reset();
      do_start(vecs[i].start_pc);
      halt      = vecs[i].h;
      branch_en = vecs[i].br;
      cond_true = vecs[i].cond;
      lut_out   = vecs[i].lut;
      tick();
      idle_inputs();
      check_all(vecs[i].name, vecs[i].exp_pc, 1,
                vecs[i].exp_run, vecs[i].exp_done, vecs[i].exp_fault);
    end

    // Five plain steps from 18.
    do_reset();
    do_start(18);
    check_all("start 18", 18, 0, 1, 0, 0);
    repeat (5) tick();
    check_all("five steps", 23, 5, 1, 0, 0);

    // Halt, DONE holds everything, restart at 0.
    do_reset();
    do_start(99);
    tick();
    halt = 1'b1; branch_en = 1'b1; cond_true = 1'b1; lut_out = 10'h010;
    tick();
    check_all("halt", 100, 2, 0, 1, 0);
    halt = 1'b0;
    repeat (3) tick();
    check_all("done hold", 100, 2, 0, 1, 0);
    idle_inputs();
    do_start(0);
    check_all("restart", 0, 0, 1, 0, 0);

    // Fault is sticky through Start; only Reset clears it.
    do_reset();
    do_start(5);
    branch_en = 1'b1; cond_true = 1'b1; lut_out = 10'h3FA;
    tick();
    idle_inputs();
    check_all("fault", 5, 1, 0, 0, 1);
    do_start(40);
    tick();
    check_all("fault after start", 5, 1, 0, 0, 1);
    do_reset();
    check_all("fault cleared", 0, 0, 0, 0, 0);
    do_start(1023);
    tick();
    do_start(7);
    check_all("top fault sticky", 1023, 1, 0, 0, 1);

    // Start ignored in RUN; reset mid-run discards the update.
    do_reset();
    do_start(298);
    start = 1'b1; start_addr = 10'd7;
    tick();
    start = 1'b0;
    check_all("start in run", 299, 1, 1, 0, 0);
    tick();
    check_all("at 300", 300, 2, 1, 0, 0);
    reset = 1'b1; branch_en = 1'b1; cond_true = 1'b1; lut_out = 10'h050;
    tick();
    idle_inputs();
    check_all("reset mid run", 0, 0, 0, 0, 0);

    // Counter saturation with a zero-offset self branch.
    do_reset();
    do_start(0);
    branch_en = 1'b1; cond_true = 1'b1; lut_out = '0;
    repeat (CNT_MAX - 1) tick();
    check_all("count max-1", 0, CNT_MAX - 1, 1, 0, 0);
    tick();
    check_all("count max", 0, CNT_MAX, 1, 0, 0);
    tick();
    check_all("count saturated", 0, CNT_MAX, 1, 0, 0);

    // Randomized run against the reference model.
    do_reset();
    m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0; m_fault = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int tgt;
      reset      = m_fault ? ($urandom_range(3) == 0) : ($urandom_range(149) == 0);
      start      = ($urandom_range(5) == 0);
      start_addr = PC_W'($urandom);
      halt       = ($urandom_range(29) == 0);
      branch_en  = ($urandom_range(2) == 0);
      cond_true  = 1'($urandom);
      lut_out    = PC_W'($urandom);
      lut_idx_in = IDX_W'($urandom);
      #1;
      check("rand lut_index", 32'(lut_index), 32'(lut_idx_in));

      if (reset) begin
        m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0; m_fault = 0;
      end else if (m_run) begin
        m_cnt = (m_cnt == CNT_MAX) ? m_cnt : m_cnt + 1;
        if (halt) begin
          m_run = 0; m_done = 1;
        end else begin
          tgt = m_pc + ((branch_en && cond_true) ? offset_of(lut_out) : 1);
          if (tgt < 0 || tgt > PC_MAX) begin
            m_run = 0; m_fault = 1;
          end else begin
            m_pc = tgt;
          end
        end
      end else if (!m_fault && start) begin
        m_pc = int'(start_addr); m_cnt = 0; m_run = 1; m_done = 0;
      end

      tick();
      check_all("random", m_pc, m_cnt, m_run, m_done, m_fault);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
